dbg_hart_ctrl: RTL
==================

DBG_HART_CTRL -- requirements
Module: dbg_hart_ctrl

Interface
REQ-001 SHALL have parameter NHARTS, default 2, meaning number of harts controlled (1..16).
REQ-002 SHALL have parameter XLEN, default 32, meaning width of PC and CSR data.
REQ-003 SHALL have parameter AR_LAT, default 1, meaning abstract-access latency in cycles (1..8).
REQ-004 SHALL define HW = max(1, clog2(NHARTS)).
REQ-005 SHALL have port clk_i, input, 1, meaning the single clock; all state on rising edge.
REQ-006 SHALL have port reset_i, input, 1, meaning reset, asynchronous and active-high.
REQ-007 SHALL have port hartsel_i, input, HW, meaning the hart targeted by haltreq, resumereq and abstract access.
REQ-008 SHALL have ports haltreq_i and resumereq_i, input, 1 each, meaning level requests to the selected hart.
REQ-009 SHALL have ports ebreak_i and retire_i, input, NHARTS each, meaning per-hart ebreak-in-MEM and instruction-retired-in-WB.
REQ-010 SHALL have port pc_i, input, NHARTS*XLEN, meaning per-hart next PC to resume at (hart h at bits [h*XLEN +: XLEN]).
REQ-011 SHALL have ports halted_o, running_o and resumeack_o, output, NHARTS each, meaning per-hart status.
REQ-012 SHALL have ports resume_o, output, NHARTS, and resume_pc_o, output, XLEN, meaning a one-cycle redirect pulse and the PC (dpc) of the resuming hart.
REQ-013 SHALL have ports ar_en_i, ar_wr_i, ar_ad_i[15:0] and ar_wdata_i[XLEN], input, meaning the abstract access request.
REQ-014 SHALL have ports ar_busy_o, ar_done_o, ar_err_o and ar_rdata_o[XLEN], output, meaning abstract access status and result.

Function
REQ-015 SHALL keep one FSM per hart with states RUNNING, HALTING, HALTED, RESUMING, and per-hart dpc and dcsr registers.
- halted_o = HALTED.
- running_o = RUNNING or HALTING.
REQ-016 SHALL move the FSM RUNNING -> HALTING when haltreq_i=1 and hartsel_i=h.
REQ-017 SHALL move the FSM HALTING -> HALTED on retire_i[h], capturing dpc<=pc_i[h] and dcsr.cause[8:6]=3.
REQ-018 SHALL move the FSM RUNNING or HALTING -> HALTED on ebreak_i[h], capturing dpc<=pc_i[h] and cause=1.
- ebreak takes priority over retire and step in the same cycle.
REQ-019 SHALL move the FSM RUNNING -> HALTED on retire_i[h] when dcsr.step[2]=1, capturing dpc and cause=4.
REQ-020 SHALL move the FSM HALTED -> RESUMING when resumereq_i=1, hartsel_i=h, haltreq_i=0, and no abstract access is busy on h.
- Haltreq wins when asserted with resumereq.
REQ-021 SHALL spend exactly one cycle in RESUMING, asserting resume_o[h] with resume_pc_o=dpc[h], then go to RUNNING.
- resumeack_o[h] is set on entering RUNNING and cleared when a haltreq targets h.
REQ-022 SHALL drive resume_pc_o from the lowest-index resuming hart (at most one, since resume is selection-driven).
REQ-023 SHALL hold dcsr fields as follows:
- xdebugver[31:28]=4 (read-only).
- prv[1:0]=3 (read-only).
- ebreakm[15] and step[2] are writable.
- All other bits read 0.
REQ-024 SHALL accept an abstract access only when ar_en_i=1 and ar_busy_o=0, latching ad, wr, wdata and hartsel.
- ar_en_i while busy is ignored.
REQ-025 SHALL hold ar_busy_o high for exactly AR_LAT cycles after acceptance.
- On the last busy cycle's edge it pulses ar_done_o for one cycle with ar_rdata_o and ar_err_o valid.
REQ-026 SHALL decode abstract addresses as follows:
- 0x07B0 is dcsr.
- 0x07B1 is dpc; a write forces bit0=0.
- Any other address gives ar_err_o=1 and rdata=0.
REQ-027 SHALL make an access to a hart not HALTED at acceptance give ar_err_o=1, with no write and rdata=0.
REQ-028 SHALL commit a write at done time.
- A hartsel_i change during busy has no effect on the access.
REQ-029 SHALL hold ar_rdata_o and ar_err_o between done pulses.

Reset
REQ-030 SHALL, while reset_i is asserted (at any time, including mid-access or mid-resume), immediately force:
- All FSMs to RUNNING.
- dpc=0 and dcsr=0x40000003.
- resumeack_o=0, resume_o=0, resume_pc_o=0.
- ar_busy_o=0, ar_done_o=0, ar_err_o=0, ar_rdata_o=0.
- running_o all ones, halted_o all zeros.

Verification
REQ-031 SHALL be verified by the halt scenario: hartsel=1, haltreq 1 cycle, retire_i[1] two cycles later with pc_i[1]=0x80 -> halted_o=2'b10, dpc1=0x80, and dcsr1 read gives 0x400000C3.
REQ-032 SHALL be verified by the ebreak scenario: ebreak_i[0] and retire_i[0] in the same cycle, pc=0x104 -> hart0 HALTED with cause=1 and dpc=0x104.
REQ-033 SHALL be verified by the resume-with-step scenario: write dcsr=0x4 to halted hart0, then resumereq -> resume_o[0] pulses one cycle with resume_pc_o=dpc, resumeack_o[0]=1, and the next retire (pc=0x108) re-halts with cause=4.
REQ-034 SHALL be verified by the abstract-access scenario with AR_LAT=3: read of 0x07B1 on a halted hart -> busy 3 cycles, done pulse, rdata=dpc, err=0; the same read on a running hart -> err=1 and rdata=0; a read of 0x1000 -> err=1.
REQ-035 SHALL be verified by the collision scenario: haltreq and resumereq both asserted on a halted hart -> stays HALTED; resumereq during busy -> no resume until done; ar_en during busy -> ignored.
REQ-036 SHALL be verified by the reset-mid-operation scenario: reset_i asserted mid-access and mid-HALTING -> all outputs at reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/dbg_hart_ctrl.sv
// ---------------------------------------------------------------------------
// dbg_hart_ctrl
//
// Debug-mode run control for NHARTS harts plus a single shared abstract
// access port onto each hart's debug CSRs (dcsr, dpc).
//
// Each hart has its own RUNNING / HALTING / HALTED / RESUMING state machine:
//   - haltreq_i to the selected hart asks it to halt at the next retirement.
//   - ebreak_i[h] halts the hart immediately. It beats retire and step.
//   - with dcsr.step set, the next retirement from RUNNING re-halts the hart.
//   - resumereq_i to a halted hart spends one cycle in RESUMING. During that
//     cycle resume_o[h] pulses and resume_pc_o carries dpc[h].
//
// The abstract access is accepted when the port is idle. It stays busy for
// AR_LAT cycles and then pulses ar_done_o. The access must target a hart
// that is HALTED at acceptance, and it commits any write when it completes.
//
// Ports
//   clk_i, reset_i               clock, asynchronous active-high reset
//   hartsel_i [HW]               target of haltreq/resumereq/abstract access
//   haltreq_i, resumereq_i       level run-control requests
//   ebreak_i, retire_i [NHARTS]  per-hart ebreak-in-MEM / retire-in-WB
//   pc_i [NHARTS*XLEN]           per-hart next PC (hart h at [h*XLEN +: XLEN])
//   halted_o, running_o,
//   resumeack_o [NHARTS]         per-hart status
//   resume_o [NHARTS]            one-cycle redirect pulse
//   resume_pc_o [XLEN]           dpc of the resuming hart
//   ar_en_i, ar_wr_i, ar_ad_i,
//   ar_wdata_i                   abstract access request
//   ar_busy_o, ar_done_o,
//   ar_err_o, ar_rdata_o         abstract access status and result
// ---------------------------------------------------------------------------
module dbg_hart_ctrl #(
    parameter  int NHARTS = 2,
    parameter  int XLEN   = 32,
    parameter  int AR_LAT = 1,
    localparam int HW     = (NHARTS > 1) ? $clog2(NHARTS) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [HW-1:0]          hartsel_i,
    input  logic                   haltreq_i,
    input  logic                   resumereq_i,
    input  logic [NHARTS-1:0]      ebreak_i,
    input  logic [NHARTS-1:0]      retire_i,
    input  logic [NHARTS*XLEN-1:0] pc_i,
    output logic [NHARTS-1:0]      halted_o,
    output logic [NHARTS-1:0]      running_o,
    output logic [NHARTS-1:0]      resumeack_o,
    output logic [NHARTS-1:0]      resume_o,
    output logic [XLEN-1:0]        resume_pc_o,
    input  logic                   ar_en_i,
    input  logic                   ar_wr_i,
    input  logic [15:0]            ar_ad_i,
    input  logic [XLEN-1:0]        ar_wdata_i,
    output logic                   ar_busy_o,
    output logic                   ar_done_o,
    output logic                   ar_err_o,
    output logic [XLEN-1:0]        ar_rdata_o
);

    localparam logic [15:0] AD_DCSR       = 16'h07B0;
    localparam logic [15:0] AD_DPC        = 16'h07B1;
    localparam logic [2:0]  CAUSE_EBREAK  = 3'd1;
    localparam logic [2:0]  CAUSE_HALTREQ = 3'd3;
    localparam logic [2:0]  CAUSE_STEP    = 3'd4;

    typedef enum logic [1:0] {
        ST_RUNNING,
        ST_HALTING,
        ST_HALTED,
        ST_RESUMING
    } hart_state_e;

    // The dcsr is stored as its live fields only. The constant fields
    // (xdebugver, prv) are added back when the register is read.
    function automatic logic [XLEN-1:0] dcsr_word(input logic       ebreakm,
                                                  input logic [2:0] cause,
                                                  input logic       step);
        logic [31:0] w;
        w = {4'h4, 12'h000, ebreakm, 6'b0, cause, 3'b0, step, 2'b11};
        return XLEN'(w);
    endfunction

    // Per-hart state
    hart_state_e       state_q [NHARTS];
    hart_state_e       state_d [NHARTS];
    logic [XLEN-1:0]   dpc_q   [NHARTS];
    logic [2:0]        cause_q [NHARTS];
    logic [NHARTS-1:0] ebreakm_q;
    logic [NHARTS-1:0] step_q;
    logic [NHARTS-1:0] resumeack_q;

    logic [NHARTS-1:0] targeted;     // hartsel_i points at this hart
    logic [NHARTS-1:0] ar_blocks;    // in-flight abstract access owns this hart
    logic [NHARTS-1:0] capture;      // halt entry: capture dpc and cause
    logic [2:0]        capture_cause [NHARTS];
    logic [NHARTS-1:0] wr_dcsr;
    logic [NHARTS-1:0] wr_dpc;

    // Abstract access state
    logic            ar_busy_q;
    logic [3:0]      ar_cnt_q;       // busy cycles left after the current one
    logic            ar_wr_q;
    logic [15:0]     ar_ad_q;
    logic [XLEN-1:0] ar_wdata_q;
    logic [HW-1:0]   ar_hart_q;
    logic            ar_ok_q;        // target hart was HALTED at acceptance
    logic            ar_done_q;
    logic            ar_err_q;
    logic [XLEN-1:0] ar_rdata_q;

    logic            ar_last;
    logic            ar_fail;
    logic            sel_halted;
    logic [XLEN-1:0] ar_read;

    always_comb begin
        for (int h = 0; h < NHARTS; h++) begin
            targeted[h]  = (hartsel_i == HW'(h));
            ar_blocks[h] = ar_busy_q && (ar_hart_q == HW'(h));
        end
    end

    // -----------------------------------------------------------------------
    // Run-control FSMs: next state and halt-capture strobes
    // -----------------------------------------------------------------------
    always_comb begin
        for (int h = 0; h < NHARTS; h++) begin
            // NOTE: every output of this block gets a default first, so no
            // path leaves a value unassigned and no latch is inferred.
            state_d[h]       = state_q[h];
            capture[h]       = 1'b0;
            capture_cause[h] = 3'd0;
            case (state_q[h])
                ST_RUNNING: begin
                    if (ebreak_i[h]) begin
                        state_d[h]       = ST_HALTED;
                        capture[h]       = 1'b1;
                        capture_cause[h] = CAUSE_EBREAK;
                    end else if (retire_i[h] && step_q[h]) begin
                        state_d[h]       = ST_HALTED;
                        capture[h]       = 1'b1;
                        capture_cause[h] = CAUSE_STEP;
                    end else if (haltreq_i && targeted[h]) begin
                        state_d[h] = ST_HALTING;
                    end
                end
                ST_HALTING: begin
                    if (ebreak_i[h]) begin
                        state_d[h]       = ST_HALTED;
                        capture[h]       = 1'b1;
                        capture_cause[h] = CAUSE_EBREAK;
                    end else if (retire_i[h]) begin
                        state_d[h]       = ST_HALTED;
                        capture[h]       = 1'b1;
                        capture_cause[h] = CAUSE_HALTREQ;
                    end
                end
                ST_HALTED: begin
                    // A simultaneous haltreq wins, and a hart with an access
                    // in flight stays halted until that access completes.
                    if (resumereq_i && targeted[h] && !haltreq_i && !ar_blocks[h]) begin
                        state_d[h] = ST_RESUMING;
                    end
                end
                ST_RESUMING: begin
                    state_d[h] = ST_RUNNING;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int h = 0; h < NHARTS; h++) begin
                state_q[h] <= ST_RUNNING;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // flop samples pre-edge values regardless of statement order.
            for (int h = 0; h < NHARTS; h++) begin
                state_q[h] <= state_d[h];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-hart debug CSRs and resume acknowledge
    // -----------------------------------------------------------------------
    // NOTE: dpc/cause are register arrays. They are reset explicitly because
    // their reset values are architecturally visible.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int h = 0; h < NHARTS; h++) begin
                dpc_q[h]   <= '0;
                cause_q[h] <= '0;
            end
            ebreakm_q   <= '0;
            step_q      <= '0;
            resumeack_q <= '0;
        end else begin
            for (int h = 0; h < NHARTS; h++) begin
                // A halt capture and a debugger write cannot coincide. A
                // write needs the hart to be HALTED, and a halted hart never
                // captures.
                if (capture[h]) begin
                    dpc_q[h]   <= pc_i[h*XLEN +: XLEN];
                    cause_q[h] <= capture_cause[h];
                end else if (wr_dpc[h]) begin
                    dpc_q[h] <= ar_wdata_q & ~XLEN'(1);
                end
                if (wr_dcsr[h]) begin
                    ebreakm_q[h] <= ar_wdata_q[15];
                    step_q[h]    <= ar_wdata_q[2];
                end
                if (state_q[h] == ST_RESUMING) begin
                    resumeack_q[h] <= 1'b1;
                end else if (haltreq_i && targeted[h]) begin
                    resumeack_q[h] <= 1'b0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Abstract access
    // -----------------------------------------------------------------------
    assign ar_last = ar_busy_q && (ar_cnt_q == 4'd0);
    assign ar_fail = !ar_ok_q || !((ar_ad_q == AD_DCSR) || (ar_ad_q == AD_DPC));

    always_comb begin
        sel_halted = 1'b0;
        ar_read    = '0;
        for (int h = 0; h < NHARTS; h++) begin
            if (targeted[h] && (state_q[h] == ST_HALTED)) begin
                sel_halted = 1'b1;
            end
            if (ar_hart_q == HW'(h)) begin
                ar_read = (ar_ad_q == AD_DCSR) ? dcsr_word(ebreakm_q[h], cause_q[h], step_q[h])
                                               : dpc_q[h];
            end
            wr_dcsr[h] = ar_last && !ar_fail && ar_wr_q && (ar_hart_q == HW'(h)) &&
                         (ar_ad_q == AD_DCSR);
            wr_dpc[h]  = ar_last && !ar_fail && ar_wr_q && (ar_hart_q == HW'(h)) &&
                         (ar_ad_q == AD_DPC);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ar_busy_q  <= 1'b0;
            ar_cnt_q   <= '0;
            ar_wr_q    <= 1'b0;
            ar_ad_q    <= '0;
            ar_wdata_q <= '0;
            ar_hart_q  <= '0;
            ar_ok_q    <= 1'b0;
            ar_done_q  <= 1'b0;
            ar_err_q   <= 1'b0;
            ar_rdata_q <= '0;
        end else begin
            ar_done_q <= 1'b0;
            if (ar_busy_q) begin
                // A new ar_en_i is ignored while busy. This includes the
                // last busy cycle.
                if (ar_cnt_q == 4'd0) begin
                    ar_busy_q  <= 1'b0;
                    ar_done_q  <= 1'b1;
                    ar_err_q   <= ar_fail;
                    ar_rdata_q <= ar_fail ? '0 : ar_read;
                end else begin
                    ar_cnt_q <= ar_cnt_q - 4'd1;
                end
            end else if (ar_en_i) begin
                ar_busy_q  <= 1'b1;
                ar_cnt_q   <= 4'(AR_LAT - 1);
                ar_wr_q    <= ar_wr_i;
                ar_ad_q    <= ar_ad_i;
                ar_wdata_q <= ar_wdata_i;
                ar_hart_q  <= hartsel_i;
                ar_ok_q    <= sel_halted;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        resume_pc_o = '0;
        // Scan downward so the lowest-index resuming hart ends up driving.
        for (int h = NHARTS - 1; h >= 0; h--) begin
            if (state_q[h] == ST_RESUMING) begin
                resume_pc_o = dpc_q[h];
            end
        end
        for (int h = 0; h < NHARTS; h++) begin
            halted_o[h]  = (state_q[h] == ST_HALTED);
            running_o[h] = (state_q[h] == ST_RUNNING) || (state_q[h] == ST_HALTING);
            resume_o[h]  = (state_q[h] == ST_RESUMING);
        end
    end

    assign resumeack_o = resumeack_q;
    assign ar_busy_o   = ar_busy_q;
    assign ar_done_o   = ar_done_q;
    assign ar_err_o    = ar_err_q;
    assign ar_rdata_o  = ar_rdata_q;

endmodule
